// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: tracks each resident warp's PC and lifecycle, and
// round-robin arbitrates READY warps into the shared issue pipeline.
module warp_scheduler #(
    parameter int WARPS_PER_CORE = 2,
    parameter int PC_WIDTH       = 8,
    parameter int WID_W          = $clog2(WARPS_PER_CORE)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               core_start,
    input  logic [WID_W:0]                     active_warps,
    input  logic [PC_WIDTH-1:0]                base_pc,
    output logic [WARPS_PER_CORE-1:0]          fetch_valid,
    output logic [WARPS_PER_CORE*PC_WIDTH-1:0] fetch_pc,
    input  logic [WARPS_PER_CORE-1:0]          fetch_ready,
    output logic                               issue_valid,
    output logic [WID_W-1:0]                   issue_warp,
    input  logic                               issue_ready,
    input  logic                               commit_valid,
    input  logic [WID_W-1:0]                   commit_warp,
    input  logic [PC_WIDTH-1:0]                commit_next_pc,
    input  logic                               commit_is_mem,
    input  logic                               commit_is_ret,
    input  logic [WARPS_PER_CORE-1:0]          mem_done,
    output logic                               core_done,
    output logic                               protocol_err
);

    typedef enum logic [2:0] {
        W_IDLE,
        W_FETCH,
        W_READY,
        W_ISSUED,
        W_WAIT_MEM,
        W_DONE
    } warp_state_t;

    localparam logic [WID_W:0] MAX_WARPS = (WID_W+1)'(WARPS_PER_CORE);

    warp_state_t         state_reg  [WARPS_PER_CORE];
    warp_state_t         state_next [WARPS_PER_CORE];
    logic [PC_WIDTH-1:0] pc_reg     [WARPS_PER_CORE];
    logic [PC_WIDTH-1:0] pc_next    [WARPS_PER_CORE];

    logic [WARPS_PER_CORE-1:0] fetch_vec;
    logic [WARPS_PER_CORE-1:0] ready_vec;
    logic [WARPS_PER_CORE-1:0] issued_vec;
    logic [WARPS_PER_CORE-1:0] quiet_vec;
    logic [WARPS_PER_CORE-1:0] done_next_vec;
    logic [WARPS_PER_CORE-1:0] commit_hit;
    logic [WARPS_PER_CORE-1:0] start_mask;

    logic [WARPS_PER_CORE-1:0] active_reg;
    logic [WARPS_PER_CORE-1:0] active_next;
    logic [WID_W-1:0]          ptr_reg;
    logic                      lock_valid_reg;
    logic [WID_W-1:0]          lock_warp_reg;
    logic                      started_reg;
    logic                      started_next;
    logic                      core_done_reg;
    logic                      protocol_err_reg;

    logic [WID_W:0]   eff;
    logic             accept_start;
    logic             handshake;
    logic             any_err;
    logic [WID_W-1:0] rr_warp;
    int               best_dist;
    int               cand_dist;

    always_comb begin
        eff = (active_warps > MAX_WARPS) ? MAX_WARPS : active_warps;
    end

    assign accept_start = core_start && (&quiet_vec);
    assign issue_valid  = |ready_vec;
    assign issue_warp   = lock_valid_reg ? lock_warp_reg : rr_warp;
    assign handshake    = issue_valid && issue_ready;
    assign fetch_valid  = fetch_vec;
    assign core_done    = core_done_reg;
    assign protocol_err = protocol_err_reg;

    // Nearest READY warp after the pointer, measured as rotational distance.
    always_comb begin
        rr_warp   = '0;
        best_dist = WARPS_PER_CORE;
        cand_dist = 0;
        for (int w = 0; w < WARPS_PER_CORE; w++) begin
            cand_dist = (w + WARPS_PER_CORE - int'(ptr_reg) - 1) % WARPS_PER_CORE;
            if (ready_vec[w] && (cand_dist < best_dist)) begin
                best_dist = cand_dist;
                rr_warp   = WID_W'(w);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WARPS_PER_CORE; gi++) begin : g_warp
            assign fetch_vec[gi]     = (state_reg[gi] == W_FETCH);
            assign ready_vec[gi]     = (state_reg[gi] == W_READY);
            assign issued_vec[gi]    = (state_reg[gi] == W_ISSUED);
            assign quiet_vec[gi]     = (state_reg[gi] == W_IDLE) || (state_reg[gi] == W_DONE);
            assign done_next_vec[gi] = (state_next[gi] == W_DONE);
            assign commit_hit[gi]    = commit_valid && (commit_warp == WID_W'(gi));
            assign start_mask[gi]    = ((WID_W+1)'(gi) < eff);
            assign fetch_pc[gi*PC_WIDTH +: PC_WIDTH] = pc_reg[gi];

            always_comb begin
                state_next[gi] = state_reg[gi];
                pc_next[gi]    = pc_reg[gi];
                if (accept_start) begin
                    if (start_mask[gi]) begin
                        state_next[gi] = W_FETCH;
                        pc_next[gi]    = base_pc;
                    end else begin
                        state_next[gi] = W_IDLE;
                    end
                end else begin
                    case (state_reg[gi])
                        W_FETCH: begin
                            if (fetch_ready[gi]) state_next[gi] = W_READY;
                        end
                        W_READY: begin
                            if (handshake && (issue_warp == WID_W'(gi))) state_next[gi] = W_ISSUED;
                        end
                        W_ISSUED: begin
                            if (commit_hit[gi]) begin
                                if (commit_is_ret) begin
                                    state_next[gi] = W_DONE;
                                end else begin
                                    state_next[gi] = commit_is_mem ? W_WAIT_MEM : W_FETCH;
                                    pc_next[gi]    = commit_next_pc;
                                end
                            end
                        end
                        W_WAIT_MEM: begin
                            if (mem_done[gi]) state_next[gi] = W_FETCH;
                        end
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg[gi] <= W_IDLE;
                    pc_reg[gi]    <= '0;
                end else begin
                    state_reg[gi] <= state_next[gi];
                    pc_reg[gi]    <= pc_next[gi];
                end
            end
        end
    endgenerate

    // A commit is legal only if it addresses a warp currently in ISSUED.
    assign any_err = (core_start && !(&quiet_vec))
                  || (|(fetch_ready & ~fetch_vec))
                  || (commit_valid && !(|(commit_hit & issued_vec)));

    assign started_next = accept_start ? 1'b1 : started_reg;
    assign active_next  = accept_start ? start_mask : active_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg          <= WID_W'(WARPS_PER_CORE - 1);
            lock_valid_reg   <= 1'b0;
            lock_warp_reg    <= '0;
            started_reg      <= 1'b0;
            active_reg       <= '0;
            core_done_reg    <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            if (handshake) begin
                ptr_reg        <= issue_warp;
                lock_valid_reg <= 1'b0;
            end else if (issue_valid) begin
                lock_valid_reg <= 1'b1;
                lock_warp_reg  <= issue_warp;
            end
            started_reg      <= started_next;
            active_reg       <= active_next;
            core_done_reg    <= started_next && (&(~active_next | done_next_vec));
            protocol_err_reg <= protocol_err_reg || any_err;
        end
    end

endmodule

// File: tb/tb_warp_scheduler.sv
// Scenario-driven bench for warp_scheduler; issued warp indices are checked
// against a scoreboard queue filled when each issue window is opened.
module tb_warp_scheduler;

    localparam int N  = 2;
    localparam int PW = 8;
    localparam int WW = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            core_start;
    logic [WW:0]     active_warps;
    logic [PW-1:0]   base_pc;
    logic [N-1:0]    fetch_valid;
    logic [N*PW-1:0] fetch_pc;
    logic [N-1:0]    fetch_ready;
    logic            issue_valid;
    logic [WW-1:0]   issue_warp;
    logic            issue_ready;
    logic            commit_valid;
    logic [WW-1:0]   commit_warp;
    logic [PW-1:0]   commit_next_pc;
    logic            commit_is_mem;
    logic            commit_is_ret;
    logic [N-1:0]    mem_done;
    logic            core_done;
    logic            protocol_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_issue_q[$];

    warp_scheduler #(.WARPS_PER_CORE(N), .PC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .core_start(core_start), .active_warps(active_warps),
        .base_pc(base_pc), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .issue_valid(issue_valid), .issue_warp(issue_warp),
        .issue_ready(issue_ready), .commit_valid(commit_valid), .commit_warp(commit_warp),
        .commit_next_pc(commit_next_pc), .commit_is_mem(commit_is_mem),
        .commit_is_ret(commit_is_ret), .mem_done(mem_done), .core_done(core_done),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Scoreboard: every accepted issue pops the next expected warp index.
    always @(negedge clk) begin
        if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
            tests_run++;
            if (exp_issue_q.size() == 0) begin
                tests_failed++;
                $display("FAIL issue_unexpected: got warp %0d, required no issue", issue_warp);
            end else begin
                automatic int exp_w = exp_issue_q.pop_front();
                if (issue_warp !== WW'(exp_w)) begin
                    tests_failed++;
                    $display("FAIL issue_order: got warp %0d, required %0d", issue_warp, exp_w);
                end else begin
                    $display("[TB] issue warp %0d ok", issue_warp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_start     = 1'b0;
        active_warps   = '0;
        base_pc        = '0;
        fetch_ready    = '0;
        issue_ready    = 1'b0;
        commit_valid   = 1'b0;
        commit_warp    = '0;
        commit_next_pc = '0;
        commit_is_mem  = 1'b0;
        commit_is_ret  = 1'b0;
        mem_done       = '0;
    endtask

    task automatic do_commit(input int w, input logic [PW-1:0] npc, input logic is_mem, input logic is_ret);
        commit_valid   = 1'b1;
        commit_warp    = WW'(w);
        commit_next_pc = npc;
        commit_is_mem  = is_mem;
        commit_is_ret  = is_ret;
        tick();
        commit_valid   = 1'b0;
        commit_is_mem  = 1'b0;
        commit_is_ret  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if ({fetch_valid, issue_valid, core_done, protocol_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got fv=%b iv=%b done=%b err=%b, required all 0",
                     fetch_valid, issue_valid, core_done, protocol_err);
        end
        tests_run++;
        if (fetch_pc !== '0 || issue_warp !== '0) begin
            tests_failed++;
            $display("FAIL reset_pc: got pc=%h iw=%0d, required 0", fetch_pc, issue_warp);
        end
    endtask

    task automatic test_start();
        core_start = 1'b1; active_warps = 2; base_pc = 8'h10;
        tick();
        core_start = 1'b0;
        tests_run++;
        if (fetch_valid !== 2'b11 || fetch_pc !== 16'h1010 || core_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL start: got fv=%b pc=%h done=%b, required 11 1010 0", fetch_valid, fetch_pc, core_done);
        end
    endtask

    task automatic test_round_robin();
        fetch_ready = 2'b11;
        tick();
        fetch_ready = 2'b00;
        exp_issue_q.push_back(0);
        exp_issue_q.push_back(1);
        issue_ready = 1'b1;
        tick();
        tick();
        issue_ready = 1'b0;
        tests_run++;
        if (issue_valid !== 1'b0 || fetch_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL rr_drain: got iv=%b fv=%b, required 0 00", issue_valid, fetch_valid);
        end
        do_commit(0, 8'h11, 1'b0, 1'b0);
        do_commit(1, 8'h21, 1'b0, 1'b0);
        tests_run++;
        if (fetch_valid !== 2'b11 || fetch_pc !== 16'h2111) begin
            tests_failed++;
            $display("FAIL rr_recommit: got fv=%b pc=%h, required 11 2111", fetch_valid, fetch_pc);
        end
        fetch_ready = 2'b11;
        tick();
        fetch_ready = 2'b00;
        exp_issue_q.push_back(0);
        exp_issue_q.push_back(1);
        issue_ready = 1'b1;
        tick();
        tick();
        issue_ready = 1'b0;
    endtask

    task automatic test_lock();
        do_commit(1, 8'h30, 1'b0, 1'b0);
        fetch_ready = 2'b10;
        tick();
        fetch_ready = 2'b00;
        do_commit(0, 8'h40, 1'b0, 1'b0);
        fetch_ready = 2'b01;
        tick();
        fetch_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (issue_valid !== 1'b1 || issue_warp !== 1'b1) begin
                tests_failed++;
                $display("FAIL lock_hold[%0d]: got iv=%b iw=%0d, required 1 1", i, issue_valid, issue_warp);
            end
            tick();
        end
        exp_issue_q.push_back(1);
        exp_issue_q.push_back(0);
        issue_ready = 1'b1;
        tick();
        tests_run++;
        if (issue_warp !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_next: got iw=%0d, required 0", issue_warp);
        end
        tick();
        issue_ready = 1'b0;
    endtask

    task automatic test_mem();
        mem_done = 2'b10;
        do_commit(0, 8'h14, 1'b1, 1'b0);
        mem_done = 2'b00;
        tests_run++;
        if (fetch_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL mem_wait: got fv=%b, required 00", fetch_valid);
        end
        mem_done = 2'b01;
        tick();
        mem_done = 2'b00;
        tests_run++;
        if (fetch_valid !== 2'b01 || fetch_pc[7:0] !== 8'h14) begin
            tests_failed++;
            $display("FAIL mem_refetch: got fv=%b pc0=%h, required 01 14", fetch_valid, fetch_pc[7:0]);
        end
        fetch_ready = 2'b01;
        tick();
        fetch_ready = 2'b00;
        exp_issue_q.push_back(0);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        tests_run++;
        if (protocol_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mem_no_err: got err=%b, required 0", protocol_err);
        end
    endtask

    task automatic test_done();
        do_commit(0, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (core_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_early: got done=%b, required 0", core_done);
        end
        do_commit(1, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (core_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_rise: got done=%b, required 1", core_done);
        end
        tick();
        tests_run++;
        if (core_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_hold: got done=%b, required 1", core_done);
        end
        core_start = 1'b1; active_warps = 2; base_pc = 8'h80;
        tick();
        core_start = 1'b0;
        tests_run++;
        if (core_done !== 1'b0 || fetch_valid !== 2'b11 || fetch_pc !== 16'h8080) begin
            tests_failed++;
            $display("FAIL done_restart: got done=%b fv=%b pc=%h, required 0 11 8080", core_done, fetch_valid, fetch_pc);
        end
    endtask

    task automatic test_protocol();
        core_start = 1'b1; active_warps = 1; base_pc = 8'h99;
        tick();
        core_start = 1'b0;
        tests_run++;
        if (protocol_err !== 1'b1 || fetch_valid !== 2'b11 || fetch_pc !== 16'h8080) begin
            tests_failed++;
            $display("FAIL busy_start: got err=%b fv=%b pc=%h, required 1 11 8080", protocol_err, fetch_valid, fetch_pc);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({fetch_valid, issue_valid, core_done, protocol_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset: got fv=%b iv=%b done=%b err=%b, required all 0",
                     fetch_valid, issue_valid, core_done, protocol_err);
        end
        do_commit(1, 8'h55, 1'b0, 1'b0);
        tests_run++;
        if (protocol_err !== 1'b1 || fetch_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_commit: got err=%b fv=%b, required 1 00", protocol_err, fetch_valid);
        end
        tick();
        tests_run++;
        if (protocol_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: got err=%b, required 1", protocol_err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_eff_bounds();
        core_start = 1'b1; active_warps = 0; base_pc = 8'h33;
        tick();
        core_start = 1'b0;
        tests_run++;
        if (core_done !== 1'b1 || fetch_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL eff_zero: got done=%b fv=%b, required 1 00", core_done, fetch_valid);
        end
        core_start = 1'b1; active_warps = 3; base_pc = 8'h55;
        tick();
        core_start = 1'b0;
        tests_run++;
        if (core_done !== 1'b0 || fetch_valid !== 2'b11 || fetch_pc !== 16'h5555 || protocol_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL eff_clamp: got done=%b fv=%b pc=%h err=%b, required 0 11 5555 0",
                     core_done, fetch_valid, fetch_pc, protocol_err);
        end
    endtask

    task automatic test_back_to_back();
        fetch_ready = 2'b11;
        tick();
        fetch_ready = 2'b00;
        exp_issue_q.push_back(0);
        exp_issue_q.push_back(1);
        issue_ready = 1'b1;
        tick();
        do_commit(0, 8'h60, 1'b0, 1'b0);
        issue_ready = 1'b0;
        tests_run++;
        if (fetch_valid !== 2'b01 || fetch_pc[7:0] !== 8'h60 || issue_valid !== 1'b0 || protocol_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_overlap: got fv=%b pc0=%h iv=%b err=%b, required 01 60 0 0",
                     fetch_valid, fetch_pc[7:0], issue_valid, protocol_err);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_round_robin();
        test_lock();
        test_mem();
        test_done();
        test_protocol();
        test_eff_bounds();
        test_back_to_back();
        tick();
        tests_run++;
        if (exp_issue_q.size() != 0) begin
            tests_failed++;
            $display("FAIL issue_pending: got %0d unissued, required 0", exp_issue_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
